// File: rtl/root_of_8.sv
// root_of_8 -- iterative integer 8th-root extractor.
//
// Returns floor(i_value^(1/8)) together with a flag that is set when the
// operand is a perfect 8th power. The search is a bit-by-bit restoring search
// from bit 7 down to bit 0. Each bit reuses one squaring path over three
// cycles: trial^2, then ^4, then ^8. A result is ready 24 cycles after the
// operand is accepted. Only one operand is in flight at a time.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   i_valid  in   operand strobe (ignored while o_ready is low)
//   i_value  in   64-bit unsigned operand
//   o_ready  out  block is idle and will accept an operand
//   o_valid  out  one-cycle result strobe
//   o_root   out  floor 8th root (0..255), zero-extended to OUT_W
//   o_exact  out  high when o_root^8 equals the operand
//
// OUT_W must be at least 8.
module root_of_8 #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [63:0]      i_value,
    output logic             o_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_root,
    output logic             o_exact
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ1  = 2'd1,
        ST_SQ2  = 2'd2,
        ST_SQ3  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [63:0]        r_val;
    logic [63:0]        r_best8;
    logic [7:0]         r_root;
    logic [2:0]         r_k;
    logic [15:0]        r_t2;
    logic [31:0]        r_t4;

    logic [7:0]         w_trial;
    logic [15:0]        w_t2;
    logic [31:0]        w_t4;
    logic [63:0]        w_t8;
    logic               w_take;
    logic [7:0]         w_root_next;
    logic [63:0]        w_best8_next;
    logic [OUT_W-1:0]   w_root_ext;

    // Shared squaring path. r_root does not change between SQ1 and SQ3 of a
    // bit, so the same trial value is valid in all three cycles.
    always_comb begin
        w_trial      = r_root | (8'd1 << r_k);
        w_t2         = {8'd0, w_trial} * {8'd0, w_trial};
        w_t4         = {16'd0, r_t2} * {16'd0, r_t2};
        // trial <= 255, so t8 < 2^64 and the product cannot overflow.
        w_t8         = {32'd0, r_t4} * {32'd0, r_t4};
        w_take       = (w_t8 <= r_val);
        w_root_next  = r_root;
        w_best8_next = r_best8;
        if (w_take) begin
            w_root_next  = w_trial;
            w_best8_next = w_t8;
        end else begin
            w_root_next  = r_root;
            w_best8_next = r_best8;
        end
        w_root_ext      = {OUT_W{1'b0}};
        w_root_ext[7:0] = w_root_next;
    end

    // Next-state decode for the search sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_next = ST_SQ1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SQ1:  w_state_next = ST_SQ2;
            ST_SQ2:  w_state_next = ST_SQ3;
            ST_SQ3: begin
                if (r_k == 3'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SQ1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Search datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_val   <= 64'd0;
            r_best8 <= 64'd0;
            r_root  <= 8'd0;
            r_k     <= 3'd0;
            r_t2    <= 16'd0;
            r_t4    <= 32'd0;
            o_valid <= 1'b0;
            o_root  <= {OUT_W{1'b0}};
            o_exact <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_val   <= i_value;
                        r_best8 <= 64'd0;
                        r_root  <= 8'd0;
                        r_k     <= 3'd7;
                    end
                end
                ST_SQ1: r_t2 <= w_t2;
                ST_SQ2: r_t4 <= w_t4;
                ST_SQ3: begin
                    r_root  <= w_root_next;
                    r_best8 <= w_best8_next;
                    if (r_k == 3'd0) begin
                        // Last bit: publish using the just-decided values.
                        o_valid <= 1'b1;
                        o_root  <= w_root_ext;
                        o_exact <= (w_best8_next == r_val);
                    end else begin
                        r_k <= r_k - 3'd1;
                    end
                end
                default: begin
                    r_k <= 3'd0;
                end
            endcase
        end
    end

    // Ready is a pure decode of the registered state.
    assign o_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_root_of_8.sv
module tb_root_of_8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_value;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_root;
    logic        o_exact;

    int checks = 0;
    int errors = 0;

    root_of_8 #(.OUT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_value (i_value),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_root  (o_root),
        .o_exact (o_exact)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pow8(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int j = 0; j < 8; j++) p = p * 64'(n);
        return p;
    endfunction

    // Accept one operand and check result, latency and the strobe width.
    task automatic run_op(input logic [63:0] v, input logic [31:0] er,
                          input logic ee, input string name);
        int lat;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", name, o_ready);
        end
        i_valid = 1'b1;
        i_value = v;
        tick();
        i_valid = 1'b0;
        i_value = 64'd0;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got ready=%b want 0", name, o_ready);
        end
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (o_valid === 1'b1) break;
        end
        checks++;
        if (lat !== 24) begin
            errors++;
            $display("FAIL %s latency: got %0d want 24", name, lat);
        end
        checks++;
        if (o_root !== er) begin
            errors++;
            $display("FAIL %s root: got %0d want %0d", name, o_root, er);
        end
        checks++;
        if (o_exact !== ee) begin
            errors++;
            $display("FAIL %s exact: got %b want %b", name, o_exact, ee);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after: got %b want 1", name, o_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_width: got %b want 0", name, o_valid);
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset   = 1'b1;
        i_valid = 1'b1;
        i_value = 64'd6561;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", o_valid); end
        checks++;
        if (o_root !== 32'd0) begin errors++; $display("FAIL reset root: got %0d want 0", o_root); end
        checks++;
        if (o_exact !== 1'b0) begin errors++; $display("FAIL reset exact: got %b want 0", o_exact); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", o_ready); end
        reset   = 1'b0;
        i_valid = 1'b0;
        pulses  = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (o_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL reset spurious: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_boundary();
        run_op(64'd0,    32'd0, 1'b1, "zero");
        run_op(64'd1,    32'd1, 1'b1, "one");
        run_op(64'd6561, 32'd3, 1'b1, "p6561");
        run_op(64'd6562, 32'd3, 1'b0, "p6562");
        run_op(64'd255,  32'd1, 1'b0, "p255");
        run_op(64'd256,  32'd2, 1'b1, "p256");
    endtask

    task automatic test_extremes();
        logic [63:0] a;
        run_op(64'd9227446944279201,    32'd99,  1'b1, "p99");
        run_op(64'd17878103347812890625, 32'd255, 1'b1, "p255_8");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd255, 1'b0, "max64");
        a = 64'd0;
        a = a - 64'd1;   // 256^8 - 1 wraps to the same all-ones pattern
        run_op(a, 32'd255, 1'b0, "alias256");
    endtask

    task automatic test_loopback();
        int n_sent, n_recv, last, cyc, extra;
        n_sent = 0;
        n_recv = 0;
        last   = 0;
        cyc    = 0;
        while (n_recv < 100 && cyc < 3000) begin
            if (o_valid === 1'b1) begin
                checks++;
                if (o_root !== 32'(n_recv)) begin
                    errors++;
                    $display("FAIL loop root[%0d]: got %0d want %0d", n_recv, o_root, n_recv);
                end
                checks++;
                if (o_exact !== 1'b1) begin
                    errors++;
                    $display("FAIL loop exact[%0d]: got %b want 1", n_recv, o_exact);
                end
                if (n_recv > 0) begin
                    checks++;
                    if (cyc - last !== 25) begin
                        errors++;
                        $display("FAIL loop spacing[%0d]: got %0d want 25", n_recv, cyc - last);
                    end
                end
                last = cyc;
                n_recv++;
            end
            if (o_ready === 1'b1 && n_sent < 100) begin
                i_valid = 1'b1;
                i_value = pow8(n_sent);
                n_sent++;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        checks++;
        if (n_recv !== 100) begin errors++; $display("FAIL loop count: got %0d want 100", n_recv); end
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL loop extra: got %0d pulses want 0", extra); end
    endtask

    task automatic test_busy_drop();
        int pulses, lat;
        logic [31:0] r;
        logic x;
        pulses = 0;
        lat    = 0;
        r      = 32'd0;
        x      = 1'b0;
        i_valid = 1'b1;
        i_value = 64'd6561;
        tick();
        for (int e = 1; e <= 60; e++) begin
            if (e == 5 || e == 20) begin
                i_valid = 1'b1;
                i_value = 64'd1000;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (o_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    lat = e;
                    r   = o_root;
                    x   = o_exact;
                end
            end
        end
        i_valid = 1'b0;
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL busy pulses: got %0d want 1", pulses); end
        checks++;
        if (lat !== 24) begin errors++; $display("FAIL busy latency: got %0d want 24", lat); end
        checks++;
        if (r !== 32'd3) begin errors++; $display("FAIL busy root: got %0d want 3", r); end
        checks++;
        if (x !== 1'b1) begin errors++; $display("FAIL busy exact: got %b want 1", x); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses  = 0;
        i_valid = 1'b1;
        i_value = 64'h0000_0100_0000_0000;
        tick();
        i_valid = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            if (e == 10) reset = 1'b1;
            tick();
            if (o_valid === 1'b1) pulses++;
        end
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midrst pulses: got %0d want 0", pulses); end
        checks++;
        if (o_root !== 32'd0) begin errors++; $display("FAIL midrst root: got %0d want 0", o_root); end
        checks++;
        if (o_exact !== 1'b0) begin errors++; $display("FAIL midrst exact: got %b want 0", o_exact); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst ready: got %b want 1", o_ready); end
        run_op(64'd256, 32'd2, 1'b1, "after_rst");
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_value = 64'd0;
        test_reset();
        test_boundary();
        test_extremes();
        test_loopback();
        test_busy_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
